// File: rtl/dawson32_fmul.sv
// dawson32_fmul: multi-cycle IEEE-754 binary32 multiplier with stb/ack handshakes, round to nearest even.
// Define DAWSON32_FMUL_DENORM_EN for subnormal inputs/results; by default subnormals flush to signed zero.
module dawson32_fmul (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  input  logic [31:0] input_b,
  input  logic        input_b_stb,
  output logic        input_b_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack,
  output logic [3:0]  state_dbg
);

  // Handshake: a word moves on a rising edge where stb and ack are both high. ack/stb are
  // registered, rise one cycle after entering GET_A/GET_B/PUT_Z and fall right after the transfer.
  typedef enum logic [3:0] {
    GET_A, GET_B, UNPACK, SPECIAL, MULTIPLY, NORMALISE, ROUND, PACK, PUT_Z
  } state_t;

  localparam logic signed [9:0] E_ZERO  = -10'sd127;
  localparam logic signed [9:0] E_INF   = 10'sd128;
  localparam logic signed [9:0] E_MIN   = -10'sd126;
  localparam logic signed [9:0] E_MAX   = 10'sd127;
  localparam logic signed [9:0] E_FLUSH = -10'sd174;

  state_t state, state_n;
  logic   a_ack_n, b_ack_n, z_stb_n;
  logic   a_xfer, b_xfer, z_xfer;

  logic [31:0]       a, b;
  logic [23:0]       a_m, b_m, z_m;
  logic signed [9:0] a_e, b_e, z_e;
  logic              a_s, b_s, z_s;
  logic [47:0]       prod;

  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, is_special;
  logic norm_done;
  logic guard_bit, round_bit, sticky_bit, round_up;
  logic [24:0] rounded;
  logic [7:0]  z_exp;

  assign a_xfer = (state == GET_A) && input_a_ack && input_a_stb;
  assign b_xfer = (state == GET_B) && input_b_ack && input_b_stb;
  assign z_xfer = (state == PUT_Z) && output_z_stb && output_z_ack;
  assign state_dbg = state;

  assign a_nan = (a_e == E_INF) && (a_m != 24'd0);
  assign b_nan = (b_e == E_INF) && (b_m != 24'd0);
  assign a_inf = (a_e == E_INF) && (a_m == 24'd0);
  assign b_inf = (b_e == E_INF) && (b_m == 24'd0);
`ifdef DAWSON32_FMUL_DENORM_EN
  assign a_zero = (a_e == E_ZERO) && (a_m == 24'd0);
  assign b_zero = (b_e == E_ZERO) && (b_m == 24'd0);
`else
  assign a_zero = (a_e == E_ZERO);
  assign b_zero = (b_e == E_ZERO);
`endif
  assign is_special = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;

  // Subnormal mode walks the product one bit per cycle until bit 46 leads or the exponent sits at -126.
`ifdef DAWSON32_FMUL_DENORM_EN
  logic norm_left, norm_right, norm_flush;
  assign norm_left  = !prod[46] && (z_e > E_MIN);
  assign norm_right = (z_e < E_MIN);
  assign norm_flush = (z_e <= E_FLUSH);
  assign norm_done  = !prod[47] && !norm_left && !norm_right;
`else
  assign norm_done  = 1'b1;
`endif

  assign guard_bit  = prod[22];
  assign round_bit  = prod[21];
  assign sticky_bit = |prod[20:0];
  assign round_up   = guard_bit & (round_bit | sticky_bit | prod[23]);
  assign rounded    = {1'b0, prod[46:23]} + {24'd0, round_up};
  assign z_exp      = z_m[23] ? 8'(z_e + 10'sd127) : 8'd0;

  always_comb begin
    state_n = state;
    a_ack_n = input_a_ack;
    b_ack_n = input_b_ack;
    z_stb_n = output_z_stb;
    case (state)
      GET_A: begin
        a_ack_n = 1'b1;
        if (a_xfer) begin
          a_ack_n = 1'b0;
          state_n = GET_B;
        end
      end
      GET_B: begin
        b_ack_n = 1'b1;
        if (b_xfer) begin
          b_ack_n = 1'b0;
          state_n = UNPACK;
        end
      end
      UNPACK:    state_n = SPECIAL;
      SPECIAL:   state_n = is_special ? PUT_Z : MULTIPLY;
      MULTIPLY:  state_n = NORMALISE;
      NORMALISE: if (norm_done) state_n = ROUND;
      ROUND:     state_n = PACK;
      PACK:      state_n = PUT_Z;
      PUT_Z: begin
        z_stb_n = 1'b1;
        if (z_xfer) begin
          z_stb_n = 1'b0;
          state_n = GET_A;
        end
      end
      default:   state_n = GET_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= GET_A;
      input_a_ack  <= 1'b0;
      input_b_ack  <= 1'b0;
      output_z_stb <= 1'b0;
    end else begin
      state        <= state_n;
      input_a_ack  <= a_ack_n;
      input_b_ack  <= b_ack_n;
      output_z_stb <= z_stb_n;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      output_z <= 32'd0;
    end else begin
      case (state)
        GET_A: if (a_xfer) a <= input_a;
        GET_B: if (b_xfer) b <= input_b;
        UNPACK: begin
          a_m <= {1'b0, a[22:0]};
          b_m <= {1'b0, b[22:0]};
          a_e <= $signed({2'b00, a[30:23]}) - 10'sd127;
          b_e <= $signed({2'b00, b[30:23]}) - 10'sd127;
          a_s <= a[31];
          b_s <= b[31];
        end
        SPECIAL: begin
          z_s <= a_s ^ b_s;
          if (a_nan || b_nan) begin
            output_z <= 32'h7FC0_0000;
          end else if (a_inf || b_inf) begin
            output_z <= (a_zero || b_zero) ? 32'h7FC0_0000 : {a_s ^ b_s, 8'hFF, 23'd0};
          end else if (a_zero || b_zero) begin
            output_z <= {a_s ^ b_s, 31'd0};
          end else begin
            // Subnormal operands keep a zero hidden bit and take the minimum exponent.
            if (a_e == E_ZERO) a_e <= E_MIN;
            else a_m[23] <= 1'b1;
            if (b_e == E_ZERO) b_e <= E_MIN;
            else b_m[23] <= 1'b1;
          end
        end
        MULTIPLY: begin
          prod <= {24'd0, a_m} * {24'd0, b_m};
          z_e  <= a_e + b_e;
        end
        NORMALISE: begin
          if (prod[47]) begin
            prod <= {1'b0, prod[47:2], prod[1] | prod[0]};
            z_e  <= z_e + 10'sd1;
          end
`ifdef DAWSON32_FMUL_DENORM_EN
          else if (norm_flush) begin
            prod <= {47'd0, |prod};
            z_e  <= E_MIN;
          end else if (norm_right) begin
            prod <= {1'b0, prod[47:2], prod[1] | prod[0]};
            z_e  <= z_e + 10'sd1;
          end else if (norm_left) begin
            prod <= {prod[46:0], 1'b0};
            z_e  <= z_e - 10'sd1;
          end
`endif
        end
        ROUND: begin
          if (rounded[24]) begin
            z_m <= rounded[24:1];
            z_e <= z_e + 10'sd1;
          end else begin
            z_m <= rounded[23:0];
          end
        end
        PACK: begin
          if (z_e > E_MAX) output_z <= {z_s, 8'hFF, 23'd0};
          else if (z_e < E_MIN) output_z <= {z_s, 31'd0};
          else output_z <= {z_s, z_exp, z_m[22:0]};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dawson32_fmul.sv
// tb_dawson32_fmul: directed handshake/corner steps plus random operands against an integer-scaling float model.
module tb_dawson32_fmul;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] input_a = 32'd0;
  logic [31:0] input_b = 32'd0;
  logic        input_a_stb = 1'b0;
  logic        input_b_stb = 1'b0;
  logic        output_z_ack = 1'b0;
  logic        input_a_ack, input_b_ack, output_z_stb;
  logic [31:0] output_z;
  logic [3:0]  state_dbg;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];

  dawson32_fmul dut (
    .clk(clk), .rst(rst),
    .input_a(input_a), .input_a_stb(input_a_stb), .input_a_ack(input_a_ack),
    .input_b(input_b), .input_b_stb(input_b_stb), .input_b_ack(input_b_ack),
    .output_z(output_z), .output_z_stb(output_z_stb), .output_z_ack(output_z_ack),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Value of a finite operand is m * 2^e with an integer significand; the product is rounded
  // by scaling to the lowest kept bit and applying nearest-even on the discarded remainder.
  function automatic logic [31:0] model_mul(input logic [31:0] x, input logic [31:0] y);
    logic        s, dn;
    logic        x_nan, y_nan, x_inf, y_inf, x_zero, y_zero;
    logic [63:0] p, n, rem, half;
    int          ex, ey, e, l, q, sh, biased;
`ifdef DAWSON32_FMUL_DENORM_EN
    dn = 1'b1;
`else
    dn = 1'b0;
`endif
    s      = x[31] ^ y[31];
    x_nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    y_nan  = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
    x_inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    y_inf  = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
    x_zero = (x[30:23] == 8'h00) && (!dn || x[22:0] == 23'd0);
    y_zero = (y[30:23] == 8'h00) && (!dn || y[22:0] == 23'd0);
    if (x_nan || y_nan) return 32'h7FC0_0000;
    if (x_inf || y_inf) return (x_zero || y_zero) ? 32'h7FC0_0000 : {s, 8'hFF, 23'd0};
    if (x_zero || y_zero) return {s, 31'd0};
    p  = {40'd0, (x[30:23] != 8'd0), x[22:0]} * {40'd0, (y[30:23] != 8'd0), y[22:0]};
    ex = (x[30:23] == 8'd0) ? -149 : int'(x[30:23]) - 150;
    ey = (y[30:23] == 8'd0) ? -149 : int'(y[30:23]) - 150;
    e  = ex + ey;
    l  = 47;
    while (l > 0 && !p[l]) l--;
    q = l + e - 23;
    if (dn && q < -149) q = -149;
    sh = q - e;
    if (sh <= 0) begin
      n = p << (-sh);
    end else if (sh > 60) begin
      n = 64'd0;
    end else begin
      n    = p >> sh;
      rem  = p & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && n[0])) n = n + 64'd1;
    end
    if (n == (64'd1 << 24)) begin
      n = 64'd1 << 23;
      q = q + 1;
    end
    if (n == 64'd0) return {s, 31'd0};
    if (n < (64'd1 << 23)) return {s, 8'h00, n[22:0]};
    biased = q + 150;
    if (biased >= 255) return {s, 8'hFF, 23'd0};
    if (biased < 1) return {s, 31'd0};
    return {s, biased[7:0], n[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0]  e;
    logic [31:0] r;
    int          k;
    k = $urandom_range(0, 9);
    r = $urandom;
    if (k <= 5) e = 8'($urandom_range(100, 154));
    else if (k == 6) e = r[30:23];
    else if (k == 7) e = 8'($urandom_range(0, 40));
    else if (k == 8) e = 8'($urandom_range(200, 254));
    else e = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
    if (k == 9 && $urandom_range(0, 1) == 1) r[22:0] = 23'd0;
    return {r[31], e, r[22:0]};
  endfunction

  task automatic send_a(input logic [31:0] x);
    int n;
    n = 0;
    input_a     = x;
    input_a_stb = 1'b1;
    while (!input_a_ack && n < 20) begin tick(); n++; end
    check("a_ack wait", 32'(input_a_ack), 32'd1);
    tick();
    input_a_stb = 1'b0;
  endtask

  task automatic send_b(input logic [31:0] x);
    int n;
    n = 0;
    input_b     = x;
    input_b_stb = 1'b1;
    while (!input_b_ack && n < 20) begin tick(); n++; end
    check("b_ack wait", 32'(input_b_ack), 32'd1);
    tick();
    input_b_stb = 1'b0;
  endtask

  // Called just after the B transfer edge; exp_lat < 0 skips the latency check.
  task automatic wait_z(input string tag, input int exp_lat, input int hold);
    int          n;
    logic [31:0] expv;
    n = 0;
    while (!output_z_stb && n < 100) begin tick(); n++; end
    check({tag, " stb"}, 32'(output_z_stb), 32'd1);
    if (exp_lat >= 0) check({tag, " latency"}, 32'(n), 32'(exp_lat));
    expv = exp_q.pop_front();
    check({tag, " z"}, output_z, expv);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, " hold stb"}, 32'(output_z_stb), 32'd1);
      check({tag, " hold z"}, output_z, expv);
    end
    output_z_ack = 1'b1;
    tick();
    output_z_ack = 1'b0;
    check({tag, " stb drop"}, 32'(output_z_stb), 32'd0);
    tick();
    check({tag, " a_ack back"}, 32'(input_a_ack), 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] expv, input int exp_lat, input int hold);
    exp_q.push_back(expv);
    send_a(x);
    send_b(y);
    wait_z(tag, exp_lat, hold);
  endtask

  initial begin
    logic [31:0] ra, rb;

    repeat (3) tick();
    check("rst a_ack", 32'(input_a_ack), 32'd0);
    check("rst b_ack", 32'(input_b_ack), 32'd0);
    check("rst z_stb", 32'(output_z_stb), 32'd0);
    check("rst z", output_z, 32'd0);
    rst = 1'b0;
    tick();
    check("a_ack after rst", 32'(input_a_ack), 32'd1);

    run_op("1.5*2", 32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 7, 0);
    run_op("-2*3", 32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000, 7, 0);
    run_op("round", 32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 7, 0);
    run_op("inf*0", 32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 3, 0);
    run_op("ovf", 32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, -1, 0);
`ifdef DAWSON32_FMUL_DENORM_EN
    run_op("unf", 32'h0080_0000, 32'h3F00_0000, 32'h0040_0000, -1, 0);
`else
    run_op("unf", 32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, -1, 0);
`endif
    run_op("-0*1", 32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 3, 0);
    run_op("-inf*-2", 32'hFF80_0000, 32'hC000_0000, 32'h7F80_0000, 3, 0);
    run_op("nan", 32'h7FC1_2345, 32'h3F80_0000, 32'h7FC0_0000, 3, 0);
    run_op("hold", 32'h4040_0000, 32'h3F00_0000, 32'h3FC0_0000, 7, 5);

    // B strobed while the block waits for A must not be acknowledged.
    input_b     = 32'hDEAD_BEEF;
    input_b_stb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("b_ack in GET_A", 32'(input_b_ack), 32'd0);
      tick();
    end
    input_b_stb = 1'b0;

    // A strobed with junk during GET_B must not replace the captured operand.
    exp_q.push_back(32'h40C0_0000);
    send_a(32'h4000_0000);
    input_a     = 32'hDEAD_BEEF;
    input_a_stb = 1'b1;
    check("a_ack in GET_B", 32'(input_a_ack), 32'd0);
    send_b(32'h4040_0000);
    input_a_stb = 1'b0;
    wait_z("a_ignored", 7, 0);

    // Reset two cycles after the B transfer lands in MULTIPLY and must discard the operation.
    send_a(32'h3F80_0000);
    send_b(32'h4000_0000);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort z_stb", 32'(output_z_stb), 32'd0);
    check("abort a_ack", 32'(input_a_ack), 32'd0);
    check("abort b_ack", 32'(input_b_ack), 32'd0);
    check("abort z", output_z, 32'd0);
    tick();
    check("abort a_ack back", 32'(input_a_ack), 32'd1);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("abort no stb", 32'(output_z_stb), 32'd0);
    end

    for (int i = 0; i < 200; i++) begin
      ra = rand_op();
      rb = rand_op();
      exp_q.push_back(model_mul(ra, rb));
      repeat ($urandom_range(0, 2)) tick();
      send_a(ra);
      send_b(rb);
      wait_z($sformatf("rnd%0d %h*%h", i, ra, rb), -1, $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dawson32_fmul.md
DAWSON32_FMUL -- requirements
Module: dawson32_fmul

Interface
REQ-001 SHALL provide: clk  input  1  sole clock; all state changes on rising edge.
REQ-002 SHALL provide: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL provide: input_a  input  32  operand A, IEEE-754 binary32.
REQ-004 SHALL provide: input_a_stb  input  1  initiator asserts input_a valid.
REQ-005 SHALL provide: input_a_ack  output  1  responder ready to take A.
REQ-006 SHALL provide: input_b  input  32  operand B, binary32.
REQ-007 SHALL provide: input_b_stb  input  1  input_b valid.
REQ-008 SHALL provide: input_b_ack  output  1  responder ready to take B.
REQ-009 SHALL provide: output_z  output  32  product A*B, binary32.
REQ-010 SHALL provide: output_z_stb  output  1  output_z valid.
REQ-011 SHALL provide: output_z_ack  input  1  initiator accepts output_z.

Function
REQ-012 SHALL implement states GET_A, GET_B, UNPACK, SPECIAL, MULTIPLY, NORMALISE, ROUND, PACK, PUT_Z.
REQ-013 SHALL assert input_a_ack only in GET_A, input_b_ack only in GET_B, output_z_stb only in PUT_Z; all three registered.
REQ-014 SHALL transfer a word on the edge where stb and ack are both high; capture operand, drop ack next cycle, advance GET_A->GET_B->UNPACK.
REQ-015 SHALL ignore input_b_stb outside GET_B and input_a_stb outside GET_A; no operand captured.
REQ-016 SHALL, for normal/finite operands, raise output_z_stb exactly 7 cycles after the B-transfer edge (UNPACK, SPECIAL, MULTIPLY, NORMALISE, ROUND, PACK, then PUT_Z).
REQ-017 SHALL, for special cases, write output_z in SPECIAL and enter PUT_Z directly: output_z_stb high 3 cycles after the B-transfer edge.
REQ-018 SHALL hold output_z and output_z_stb stable in PUT_Z until output_z_ack; on transfer edge drop stb and return to GET_A (input_a_ack high next cycle).
REQ-019 SHALL compute sign = sign(A) XOR sign(B) for every result including zero, infinity.
REQ-020 SHALL specials: either NaN -> 0x7FC00000; inf*zero -> 0x7FC00000; inf*nonzero -> signed inf; zero*finite -> signed zero.
REQ-021 SHALL form 24x24 -> 48-bit mantissa product, exponent = ea+eb-127; if product bit 47 set, shift right 1, exponent+1.
REQ-022 SHALL round to nearest, ties to even, using guard, round, sticky from discarded product bits.
REQ-023 SHALL, when rounding carries out of the mantissa, shift right 1 and increment exponent.
REQ-024 SHALL, when final biased exponent >= 255, output signed infinity (0x7F800000 | sign).
REQ-025 SHALL, on underflow (biased exponent < 1), behave per REQ-030/REQ-031.

Reset
REQ-026 SHALL, while rst high at an edge: state GET_A, input_a_ack=0, input_b_ack=0, output_z_stb=0, output_z=0.
REQ-027 SHALL assert input_a_ack in the first cycle after rst deasserts.
REQ-028 SHALL abandon any operation in progress on rst, including PUT_Z; stb falls after the reset edge, no result delivered.

Configuration
REQ-029 SHALL use macro DAWSON32_FMUL_DENORM_EN to select subnormal handling.
REQ-030 SHALL, without DAWSON32_FMUL_DENORM_EN: treat subnormal inputs as signed zero; flush underflowed results to signed zero; latency per REQ-016/017 fixed.
REQ-031 SHALL, with DAWSON32_FMUL_DENORM_EN: normalise subnormal inputs in NORMALISE (1 bit/cycle); denormalise underflow by right shift to exponent -126 with sticky accumulation, then round; latency variable, at most 7+48 cycles after B transfer.

Verification
REQ-032 SHALL test 0x3FC00000 * 0x40000000 -> 0x40400000, stb exactly 7 cycles after B transfer.
REQ-033 SHALL test 0xC0000000 * 0x40400000 -> 0xC0C00000; 0x3F800001 * 0x3F800001 -> 0x3F800002 (rounding).
REQ-034 SHALL test 0x7F800000 * 0x00000000 -> 0x7FC00000 at 3 cycles; 0x7F000000 * 0x40000000 -> 0x7F800000.
REQ-035 SHALL test 0x00800000 * 0x3F000000 -> 0x00000000 without macro, 0x00400000 with macro.
REQ-036 SHALL test output_z_ack held low 5 cycles: output_z and stb stable; B strobed during GET_A ignored; rst in MULTIPLY -> no stb, input_a_ack high after release.
